axil_cfg_master: RTL and testbench

- Command-driven AXI-lite master that sequences single register writes and reads into the team's AXI-lite register slave.
- Accepts one command at a time from a local requester: a config sequencer, a CPU bridge or a testbench driver.
- Drives the full five-channel AXI-lite master handshake and returns a single response beat (read data plus RESP) to the requester.
- Keeps the requester fully decoupled from AXI channel ordering.

---
 rtl/axil_pkg.sv | 19 +
 rtl/axil_valid_hold.sv | 25 ++
 rtl/axil_cfg_master.sv | 141 ++++++++++++++
 tb/tb_axil_cfg_master.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared AXI-lite definitions: master FSM state encoding and RESP codes.
// Imported by the config master and its valid-hold helper.
package axil_pkg;

  typedef logic [2:0] axil_state_t;

  localparam axil_state_t ST_IDLE    = 3'd0;
  localparam axil_state_t ST_WR_REQ  = 3'd1;
  localparam axil_state_t ST_WR_RESP = 3'd2;
  localparam axil_state_t ST_RD_REQ  = 3'd3;
  localparam axil_state_t ST_RD_RESP = 3'd4;
  localparam axil_state_t ST_RSP     = 3'd5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_valid_hold.sv
// VALID holder for one AXI channel: rises the cycle after i_start, falls the cycle after VALID && READY.
// No internal latency beyond that register; never drops VALID before its handshake.
module axil_valid_hold (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_ready,
  output logic o_valid
);

  logic r_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
    end else if (i_start) begin
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;

endmodule

// File: rtl/axil_cfg_master.sv
// Single-command AXI-lite master: one register write or read per command, returned as one response beat.
// Accept to RSP_VALID is 3 cycles with a zero-wait slave; CMD_READY only in IDLE, response held until RSP_READY.
module axil_cfg_master
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARST,
  input  logic                    CMD_VALID,
  output logic                    CMD_READY,
  input  logic                    CMD_WRITE,
  input  logic [ADDR_WIDTH-1:0]   CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]   CMD_WDATA,
  input  logic [DATA_WIDTH/8-1:0] CMD_WSTRB,
  output logic                    RSP_VALID,
  input  logic                    RSP_READY,
  output logic [DATA_WIDTH-1:0]   RSP_RDATA,
  output logic [1:0]              RSP_RESP,
  output logic                    RSP_WRITE,
  output logic [ADDR_WIDTH-1:0]   AW_ADDR,
  output logic                    AW_VALID,
  input  logic                    AW_READY,
  output logic [DATA_WIDTH-1:0]   W_DATA,
  output logic [DATA_WIDTH/8-1:0] W_STRB,
  output logic                    W_VALID,
  input  logic                    W_READY,
  input  logic [1:0]              B_RESP,
  input  logic                    B_VALID,
  output logic                    B_READY,
  output logic [ADDR_WIDTH-1:0]   AR_ADDR,
  output logic                    AR_VALID,
  input  logic                    AR_READY,
  input  logic [DATA_WIDTH-1:0]   R_DATA,
  input  logic [1:0]              R_RESP,
  input  logic                    R_VALID,
  output logic                    R_READY
);

  axil_state_t             r_state;
  axil_state_t             w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_wstrb;
  logic                    r_write;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [1:0]              r_resp;

  logic w_accept;
  logic w_wr_start;
  logic w_aw_vld;
  logic w_w_vld;
  logic w_wr_last;
  logic w_b_fire;
  logic w_r_fire;

  assign w_accept   = CMD_VALID && (r_state == ST_IDLE);
  assign w_wr_start = w_accept && CMD_WRITE;

  axil_valid_hold u_aw_hold (
    .i_clk   (ACLK),
    .i_rst   (ARST),
    .i_start (w_wr_start),
    .i_ready (AW_READY),
    .o_valid (w_aw_vld)
  );

  axil_valid_hold u_w_hold (
    .i_clk   (ACLK),
    .i_rst   (ARST),
    .i_start (w_wr_start),
    .i_ready (W_READY),
    .o_valid (w_w_vld)
  );

  // A low valid inside WR_REQ means that channel has already handshaken.
  assign w_wr_last = (r_state == ST_WR_REQ) &&
                     (!w_aw_vld || AW_READY) && (!w_w_vld || W_READY);

  // Ready is also offered on the completing request cycle so an early response is captured.
  assign B_READY  = (r_state == ST_WR_RESP) || w_wr_last;
  assign R_READY  = (r_state == ST_RD_RESP) || ((r_state == ST_RD_REQ) && AR_READY);
  assign w_b_fire = B_VALID && B_READY;
  assign w_r_fire = R_VALID && R_READY;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (CMD_VALID) w_state_nxt = CMD_WRITE ? ST_WR_REQ : ST_RD_REQ;
      ST_WR_REQ:  if (w_wr_last) w_state_nxt = B_VALID ? ST_RSP : ST_WR_RESP;
      ST_WR_RESP: if (B_VALID)   w_state_nxt = ST_RSP;
      ST_RD_REQ:  if (AR_READY)  w_state_nxt = R_VALID ? ST_RSP : ST_RD_RESP;
      ST_RD_RESP: if (R_VALID)   w_state_nxt = ST_RSP;
      ST_RSP:     if (RSP_READY) w_state_nxt = ST_IDLE;
      default:                   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_write <= 1'b0;
      r_rdata <= '0;
      r_resp  <= RESP_OKAY;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr  <= CMD_ADDR;
        r_wdata <= CMD_WDATA;
        r_wstrb <= CMD_WSTRB;
        r_write <= CMD_WRITE;
      end
      if (w_b_fire) begin
        r_rdata <= '0;
        r_resp  <= B_RESP;
      end
      if (w_r_fire) begin
        r_rdata <= R_DATA;
        r_resp  <= R_RESP;
      end
    end
  end

  assign CMD_READY = (r_state == ST_IDLE);
  assign RSP_VALID = (r_state == ST_RSP);
  assign RSP_RDATA = r_rdata;
  assign RSP_RESP  = r_resp;
  assign RSP_WRITE = r_write;
  assign AW_ADDR   = r_addr;
  assign AW_VALID  = w_aw_vld;
  assign W_DATA    = r_wdata;
  assign W_STRB    = r_wstrb;
  assign W_VALID   = w_w_vld;
  assign AR_ADDR   = r_addr;
  assign AR_VALID  = (r_state == ST_RD_REQ);

endmodule

// File: tb/tb_axil_cfg_master.sv
// Bench for axil_cfg_master: directed cases plus random commands against a delay-configurable register slave.
// Expected responses, latencies and readback data come from a byte-merged shadow register array.
module tb_axil_cfg_master;
  import axil_pkg::*;

  logic clk = 1'b0;
  logic ARST;
  logic CMD_VALID, CMD_READY, CMD_WRITE;
  logic [3:0] CMD_ADDR, CMD_WSTRB;
  logic [31:0] CMD_WDATA;
  logic RSP_VALID, RSP_READY, RSP_WRITE;
  logic [31:0] RSP_RDATA;
  logic [1:0] RSP_RESP;
  logic [3:0] AW_ADDR, W_STRB, AR_ADDR;
  logic AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;
  logic AR_VALID, AR_READY, R_VALID, R_READY;
  logic [31:0] W_DATA, R_DATA;
  logic [1:0] B_RESP, R_RESP;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axil_cfg_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .ACLK(clk), .ARST(ARST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_WSTRB(CMD_WSTRB),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
    .RSP_RESP(RSP_RESP), .RSP_WRITE(RSP_WRITE),
    .AW_ADDR(AW_ADDR), .AW_VALID(AW_VALID), .AW_READY(AW_READY),
    .W_DATA(W_DATA), .W_STRB(W_STRB), .W_VALID(W_VALID), .W_READY(W_READY),
    .B_RESP(B_RESP), .B_VALID(B_VALID), .B_READY(B_READY),
    .AR_ADDR(AR_ADDR), .AR_VALID(AR_VALID), .AR_READY(AR_READY),
    .R_DATA(R_DATA), .R_RESP(R_RESP), .R_VALID(R_VALID), .R_READY(R_READY)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- register slave with per-channel ready/response delays ----------------
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] b_resp_cfg = RESP_OKAY, r_resp_cfg = RESP_OKAY;
  int aw_wait, w_wait, b_wait, ar_wait, r_wait;
  logic s_aw_done, s_w_done, s_ar_done;
  logic [3:0] s_awaddr, s_wstrb, s_araddr;
  logic [31:0] s_wdata;
  logic [31:0] mem [4];

  assign AW_READY = (aw_wait >= aw_dly);
  assign W_READY  = (w_wait >= w_dly);
  assign AR_READY = (ar_wait >= ar_dly);

  wire aw_fire = AW_VALID && AW_READY;
  wire w_fire  = W_VALID && W_READY;
  wire ar_fire = AR_VALID && AR_READY;
  wire aw_ok   = s_aw_done || aw_fire;
  wire w_ok    = s_w_done || w_fire;
  wire ar_ok   = s_ar_done || ar_fire;
  wire [3:0]  eff_awaddr = s_aw_done ? s_awaddr : AW_ADDR;
  wire [3:0]  eff_wstrb  = s_w_done ? s_wstrb : W_STRB;
  wire [31:0] eff_wdata  = s_w_done ? s_wdata : W_DATA;
  wire [3:0]  eff_araddr = s_ar_done ? s_araddr : AR_ADDR;

  always @(posedge clk or posedge ARST) begin
    if (ARST) begin
      aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
      s_aw_done <= 1'b0; s_w_done <= 1'b0; s_ar_done <= 1'b0;
      s_awaddr <= '0; s_wstrb <= '0; s_wdata <= '0; s_araddr <= '0;
      B_VALID <= 1'b0; B_RESP <= '0; R_VALID <= 1'b0; R_DATA <= '0; R_RESP <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      if (aw_fire) begin
        s_aw_done <= 1'b1; s_awaddr <= AW_ADDR; aw_wait <= 0;
      end else if (AW_VALID) aw_wait <= aw_wait + 1;
      if (w_fire) begin
        s_w_done <= 1'b1; s_wdata <= W_DATA; s_wstrb <= W_STRB; w_wait <= 0;
      end else if (W_VALID) w_wait <= w_wait + 1;
      if (B_VALID && B_READY) B_VALID <= 1'b0;
      if (aw_ok && w_ok && !B_VALID) begin
        if (b_wait >= b_dly) begin
          B_VALID <= 1'b1; B_RESP <= b_resp_cfg; b_wait <= 0;
          s_aw_done <= 1'b0; s_w_done <= 1'b0;
          for (int i = 0; i < 4; i++)
            if (eff_wstrb[i]) mem[eff_awaddr[3:2]][8*i +: 8] <= eff_wdata[8*i +: 8];
        end else b_wait <= b_wait + 1;
      end
      if (ar_fire) begin
        s_ar_done <= 1'b1; s_araddr <= AR_ADDR; ar_wait <= 0;
      end else if (AR_VALID) ar_wait <= ar_wait + 1;
      if (R_VALID && R_READY) R_VALID <= 1'b0;
      if (ar_ok && !R_VALID) begin
        if (r_wait >= r_dly) begin
          R_VALID <= 1'b1; R_DATA <= mem[eff_araddr[3:2]]; R_RESP <= r_resp_cfg;
          r_wait <= 0; s_ar_done <= 1'b0;
        end else r_wait <= r_wait + 1;
      end
    end
  end

  // ---------------- protocol monitor: no VALID drops or payload change before handshake ----------------
  int aw_cyc, w_cyc, b_hs, r_hs;
  logic p_aw_v, p_aw_r, p_w_v, p_w_r, p_ar_v, p_ar_r, p_rsp_v, p_rsp_r;
  logic [3:0] p_aw_a, p_ar_a, p_w_s;
  logic [31:0] p_w_d;
  logic [34:0] p_rsp;

  initial begin : monitor
    {p_aw_v, p_aw_r, p_w_v, p_w_r, p_ar_v, p_ar_r, p_rsp_v, p_rsp_r} = '0;
    forever begin
      @(negedge clk); #1;
      if (ARST) begin
        {p_aw_v, p_w_v, p_ar_v, p_rsp_v} = '0;
      end else begin
        if (p_aw_v && !p_aw_r) chk("aw_hold", {AW_VALID, AW_ADDR}, {1'b1, p_aw_a});
        if (p_w_v && !p_w_r) chk("w_hold", {W_VALID, W_STRB, W_DATA}, {1'b1, p_w_s, p_w_d});
        if (p_ar_v && !p_ar_r) chk("ar_hold", {AR_VALID, AR_ADDR}, {1'b1, p_ar_a});
        if (p_rsp_v && !p_rsp_r)
          chk("rsp_hold", {RSP_VALID, RSP_WRITE, RSP_RESP, RSP_RDATA}, {1'b1, p_rsp});
        if (AW_VALID) aw_cyc++;
        if (W_VALID) w_cyc++;
        if (B_VALID && B_READY) b_hs++;
        if (R_VALID && R_READY) r_hs++;
        p_aw_v = AW_VALID; p_aw_r = AW_READY; p_aw_a = AW_ADDR;
        p_w_v = W_VALID; p_w_r = W_READY; p_w_d = W_DATA; p_w_s = W_STRB;
        p_ar_v = AR_VALID; p_ar_r = AR_READY; p_ar_a = AR_ADDR;
        p_rsp_v = RSP_VALID; p_rsp_r = RSP_READY; p_rsp = {RSP_WRITE, RSP_RESP, RSP_RDATA};
      end
    end
  end

  // ---------------- reference model and command driver ----------------
  logic [31:0] shadow [4];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  // Called at a negedge; returns at the negedge after the response handshake.
  task automatic run_cmd(input logic wr, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int hold, output logic [31:0] rd, output logic [1:0] rs, output logic rw,
                         output int lat, output logic [2:0] fv);
    int n;
    aw_cyc = 0; w_cyc = 0; b_hs = 0; r_hs = 0;
    CMD_WRITE = wr; CMD_ADDR = a; CMD_WDATA = d; CMD_WSTRB = s; CMD_VALID = 1'b1;
    n = 0;
    while (!CMD_READY && n < 100) begin @(negedge clk); n++; end
    chk("cmd_ready_wait", CMD_READY, 1);
    @(negedge clk);
    CMD_VALID = 1'b0;
    fv = {AW_VALID, W_VALID, AR_VALID};
    lat = 1;
    while (!RSP_VALID && lat < 300) begin @(negedge clk); lat++; end
    chk("rsp_valid_wait", RSP_VALID, 1);
    rd = RSP_RDATA; rs = RSP_RESP; rw = RSP_WRITE;
    for (int i = 0; i < hold; i++) begin
      CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 4'h0;
      @(negedge clk);
      chk("hold_cmd_ready", CMD_READY, 0);
    end
    CMD_VALID = 1'b0;
    RSP_READY = 1'b1;
    @(negedge clk);
    RSP_READY = 1'b0;
    chk("post_rsp_state", {CMD_READY, RSP_VALID, AR_VALID, AW_VALID}, 4'b1000);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog expired before the bench finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] rd, d, exp_rd;
    logic [1:0] rs, exp_rs;
    logic [3:0] a, s;
    logic [2:0] fv;
    logic rw, wr;
    int lat, n, hold, mx;

    ARST = 1'b1; CMD_VALID = 0; CMD_WRITE = 0; CMD_ADDR = 0; CMD_WDATA = 0; CMD_WSTRB = 0; RSP_READY = 0;
    for (int i = 0; i < 4; i++) shadow[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctrl", {CMD_READY, RSP_VALID, AW_VALID, W_VALID, B_READY, AR_VALID, R_READY, RSP_WRITE, RSP_RESP},
        10'h200);
    chk("reset_rdata", RSP_RDATA, 0);
    chk("reset_bus", {AW_ADDR, AR_ADDR, W_STRB, W_DATA}, 0);
    @(negedge clk);
    ARST = 1'b0;
    @(negedge clk);

    // zero-wait write
    run_cmd(1'b1, 4'h4, 32'hDEADBEEF, 4'hF, 0, rd, rs, rw, lat, fv);
    shadow[1] = merge(shadow[1], 32'hDEADBEEF, 4'hF);
    chk("wr0_latency", lat, 3);
    chk("wr0_valids_together", fv, 3'b110);
    chk("wr0_rsp", {rw, rs, rd}, {1'b1, RESP_OKAY, 32'h0});
    chk("wr0_counts", {8'(aw_cyc), 8'(w_cyc), 8'(b_hs)}, 24'h010101);

    // AW_READY delayed 3 cycles, W immediate
    aw_dly = 3; b_resp_cfg = RESP_EXOKAY;
    run_cmd(1'b1, 4'h8, 32'h12345678, 4'hF, 0, rd, rs, rw, lat, fv);
    shadow[2] = merge(shadow[2], 32'h12345678, 4'hF);
    chk("wr1_counts", {8'(aw_cyc), 8'(w_cyc), 8'(b_hs)}, 24'h040101);
    chk("wr1_latency", lat, 6);
    chk("wr1_rsp", {rw, rs, rd}, {1'b1, RESP_EXOKAY, 32'h0});

    // read with R_VALID delayed 5 cycles, SLVERR
    aw_dly = 0; r_dly = 5; r_resp_cfg = RESP_SLVERR;
    run_cmd(1'b0, 4'h8, 32'h0, 4'h0, 0, rd, rs, rw, lat, fv);
    chk("rd0_rsp", {rw, rs, rd}, {1'b0, RESP_SLVERR, shadow[2]});
    chk("rd0_latency", lat, 8);
    chk("rd0_ar_first", fv, 3'b001);
    chk("rd0_r_hs", r_hs, 1);

    // response held off 4 cycles, stray command ignored
    r_dly = 0; r_resp_cfg = RESP_OKAY;
    run_cmd(1'b0, 4'h4, 32'h0, 4'h0, 4, rd, rs, rw, lat, fv);
    chk("rd1_rsp", {rw, rs, rd}, {1'b0, RESP_OKAY, shadow[1]});

    // reset asserted while waiting for B
    b_dly = 10;
    CMD_WRITE = 1'b1; CMD_ADDR = 4'hC; CMD_WDATA = 32'hA5A5A5A5; CMD_WSTRB = 4'hF; CMD_VALID = 1'b1;
    @(negedge clk);
    CMD_VALID = 1'b0;
    @(negedge clk);
    chk("rst_in_wr_resp", {B_READY, AW_VALID, W_VALID, CMD_READY}, 4'b1000);
    ARST = 1'b1;
    #1;
    chk("rst_ctrl", {CMD_READY, RSP_VALID, AW_VALID, W_VALID, B_READY, AR_VALID, R_READY, RSP_WRITE, RSP_RESP},
        10'h200);
    chk("rst_data", {RSP_RDATA, AW_ADDR, W_STRB, AR_ADDR}, 0);
    for (int i = 0; i < 4; i++) shadow[i] = '0;
    b_dly = 0; b_resp_cfg = RESP_OKAY;
    @(negedge clk);
    ARST = 1'b0;
    @(negedge clk);
    chk("rst_release_idle", {CMD_READY, B_READY, RSP_VALID}, 3'b100);
    run_cmd(1'b0, 4'hC, 32'h0, 4'h0, 0, rd, rs, rw, lat, fv);
    chk("rst_read_rsp", {rw, rs, rd}, {1'b0, RESP_OKAY, shadow[3]});
    chk("rst_read_latency", lat, 3);

    // random back-to-back commands
    for (int k = 0; k < 16; k++) begin
      wr = 1'($urandom); a = 4'($urandom); d = $urandom; s = 4'($urandom);
      aw_dly = int'($urandom_range(0, 3)); w_dly = int'($urandom_range(0, 3));
      b_dly = int'($urandom_range(0, 3)); ar_dly = int'($urandom_range(0, 3));
      r_dly = int'($urandom_range(0, 3));
      b_resp_cfg = 2'($urandom); r_resp_cfg = 2'($urandom);
      hold = int'($urandom_range(0, 2));
      run_cmd(wr, a, d, s, hold, rd, rs, rw, lat, fv);
      if (wr) begin
        mx = (aw_dly > w_dly) ? aw_dly : w_dly;
        exp_rd = 32'h0; exp_rs = b_resp_cfg; n = 3 + mx + b_dly;
        shadow[a[3:2]] = merge(shadow[a[3:2]], d, s);
      end else begin
        exp_rd = shadow[a[3:2]]; exp_rs = r_resp_cfg; n = 3 + ar_dly + r_dly;
      end
      chk("rand_rsp", {rw, rs, rd}, {wr, exp_rs, exp_rd});
      chk("rand_latency", lat, n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
